// File: rtl/argmax_classifier.sv
// argmax_classifier: the final inference stage, placed after the ten layer-2 neurons.
//
// When start is pulsed, the block captures the packed signed scores into a snapshot.
// It then scans the snapshot one class per clock and reports the index of the
// largest score. On equal scores the lowest index wins, because the compare is
// strictly greater-than. A scan takes NUM_CLASSES-1 cycles. The result is
// announced by a single-cycle digit_valid strobe. The digit, led_onehot and
// best_score outputs hold their values until the next result or reset.
//
// Optional feature, enabled by defining ARGMAX_CONFIDENCE_EN:
//   The block also tracks the runner-up score. It reports margin (best minus
//   runner-up, saturated) and low_conf (margin < MARGIN_THRESH).
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   start         one-cycle pulse; captures scores and begins a scan (ignored while busy)
//   scores        NUM_CLASSES packed signed scores; class k at [k*DATA_WIDTH +: DATA_WIDTH]
//   busy          high while a scan is in progress
//   digit_valid   one-cycle result strobe
//   digit         predicted class index
//   led_onehot    one-hot of digit (drives LEDR)
//   best_score    winning signed score
//   margin        best minus runner-up score (only with ARGMAX_CONFIDENCE_EN)
//   low_conf      margin < MARGIN_THRESH (only with ARGMAX_CONFIDENCE_EN)
module argmax_classifier #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int IDX_WIDTH   = 4
`ifdef ARGMAX_CONFIDENCE_EN
  ,
  parameter logic signed [DATA_WIDTH-1:0] MARGIN_THRESH = 32'sd256
`endif
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [NUM_CLASSES*DATA_WIDTH-1:0] scores,
  output logic                              busy,
  output logic                              digit_valid,
  output logic [IDX_WIDTH-1:0]              digit,
  output logic [NUM_CLASSES-1:0]            led_onehot,
  output logic signed [DATA_WIDTH-1:0]      best_score
`ifdef ARGMAX_CONFIDENCE_EN
  ,
  output logic signed [DATA_WIDTH-1:0]      margin,
  output logic                              low_conf
`endif
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SCAN = 1'b1;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

  logic [0:0]                               state;
  logic [NUM_CLASSES-1:0][DATA_WIDTH-1:0]   snap;
  logic [IDX_WIDTH-1:0]                     idx;
  logic [IDX_WIDTH-1:0]                     best_idx;
  logic signed [DATA_WIDTH-1:0]             best_val;

  logic signed [DATA_WIDTH-1:0]             cur;
  logic                                     take;
  logic signed [DATA_WIDTH-1:0]             nxt_best_val;
  logic [IDX_WIDTH-1:0]                     nxt_best_idx;
  logic [NUM_CLASSES-1:0]                   nxt_onehot;

  // A single comparator is shared by the whole scan. The index mux selects the
  // class currently being examined.
  always_comb begin
    cur          = snap[idx];
    take         = cur > best_val;
    nxt_best_val = take ? cur : best_val;
    nxt_best_idx = take ? idx : best_idx;
    nxt_onehot   = {{(NUM_CLASSES-1){1'b0}}, 1'b1} << nxt_best_idx;
  end

`ifdef ARGMAX_CONFIDENCE_EN
  localparam logic signed [DATA_WIDTH-1:0] S_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [DATA_WIDTH-1:0] S_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  logic signed [DATA_WIDTH-1:0] second_val;
  logic signed [DATA_WIDTH-1:0] nxt_second;
  logic signed [DATA_WIDTH:0]   diff;
  logic signed [DATA_WIDTH-1:0] nxt_margin;

  // When a new best displaces the old one, the old best becomes the runner-up.
  // A score equal to the best counts as a runner-up, which gives a margin of 0.
  always_comb begin
    nxt_second = take ? best_val : ((cur > second_val) ? cur : second_val);
    diff       = {nxt_best_val[DATA_WIDTH-1], nxt_best_val}
               - {nxt_second[DATA_WIDTH-1], nxt_second};
    // Overflow shows up as a mismatch between the two top bits of the
    // DATA_WIDTH+1 result. In that case clamp to the representable range.
    if (diff[DATA_WIDTH] != diff[DATA_WIDTH-1])
      nxt_margin = diff[DATA_WIDTH] ? S_MIN : S_MAX;
    else
      nxt_margin = diff[DATA_WIDTH-1:0];
  end
`endif

  // The snapshot has no reset because it is always loaded before it is read.
  always_ff @(posedge clk) begin
    if (start && state == S_IDLE && !rst) snap <= scores;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      digit_valid <= 1'b0;
      digit       <= '0;
      led_onehot  <= '0;
      best_score  <= '0;
      idx         <= '0;
      best_idx    <= '0;
      best_val    <= '0;
`ifdef ARGMAX_CONFIDENCE_EN
      second_val  <= '0;
      margin      <= '0;
      low_conf    <= 1'b0;
`endif
    end else begin
      digit_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            // Class 0 seeds the running best, so the scan itself begins at class 1.
            best_val <= scores[0 +: DATA_WIDTH];
            best_idx <= '0;
            idx      <= IDX_WIDTH'(1);
            busy     <= 1'b1;
            state    <= S_SCAN;
`ifdef ARGMAX_CONFIDENCE_EN
            second_val <= S_MIN;
`endif
          end
        end
        S_SCAN: begin
          best_val <= nxt_best_val;
          best_idx <= nxt_best_idx;
          idx      <= idx + 1'b1;
`ifdef ARGMAX_CONFIDENCE_EN
          second_val <= nxt_second;
`endif
          if (idx == LAST_IDX) begin
            digit       <= nxt_best_idx;
            best_score  <= nxt_best_val;
            led_onehot  <= nxt_onehot;
            digit_valid <= 1'b1;
            busy        <= 1'b0;
            state       <= S_IDLE;
`ifdef ARGMAX_CONFIDENCE_EN
            margin      <= nxt_margin;
            low_conf    <= nxt_margin < MARGIN_THRESH;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_argmax_classifier.sv
// Testbench for argmax_classifier.
// Each result is compared with a reference model: the first maximum over an
// integer array, and the runner-up taken as the maximum of all other entries.
module tb_argmax_classifier;
  localparam int N = 10;
  localparam int W = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [N*W-1:0]     scores;
  logic               busy;
  logic               digit_valid;
  logic [3:0]         digit;
  logic [N-1:0]       led_onehot;
  logic [W-1:0]       best_score;
`ifdef ARGMAX_CONFIDENCE_EN
  logic [W-1:0]       margin;
  logic               low_conf;
`endif

  always #5 clk = ~clk;

  argmax_classifier dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .scores      (scores),
    .busy        (busy),
    .digit_valid (digit_valid),
    .digit       (digit),
    .led_onehot  (led_onehot),
    .best_score  (best_score)
`ifdef ARGMAX_CONFIDENCE_EN
    ,
    .margin      (margin),
    .low_conf    (low_conf)
`endif
  );

  int     n_total = 0;
  int     n_pass  = 0;
  int     sv[N];
  int     exp_sv[N];
  int     m_idx;
  int     m_best;
  longint m_margin;
  logic   m_low;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
  endtask

  function automatic void ref_model();
    longint best, second;
    m_idx = 0;
    best  = exp_sv[0];
    for (int k = 1; k < N; k++)
      if (exp_sv[k] > best) begin best = exp_sv[k]; m_idx = k; end
    second = -64'sd2147483648;
    for (int k = 0; k < N; k++)
      if (k != m_idx && exp_sv[k] > second) second = exp_sv[k];
    m_best   = int'(best);
    m_margin = best - second;
    if (m_margin > 64'sd2147483647) m_margin = 64'sd2147483647;
    m_low    = (m_margin < 256);
  endfunction

  // Must be called on a falling edge. The scan starts at the following rising edge.
  task automatic start_pulse();
    for (int k = 0; k < N; k++) scores[k*W +: W] = sv[k];
    exp_sv = sv;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Returns on the falling edge at which digit_valid is high.
  task automatic wait_result(input string tag);
    int cyc;
    int bcyc;
    logic [N-1:0] e_led;
    cyc  = 0;
    bcyc = 0;
    ref_model();
    while (digit_valid !== 1'b1 && cyc < 40) begin
      if (busy === 1'b1) bcyc++;
      @(negedge clk);
      cyc++;
    end
    e_led = '0;
    e_led[m_idx] = 1'b1;
    chk({tag, ".latency"},   cyc,         N-1);
    chk({tag, ".busy_cyc"},  bcyc,        N-1);
    chk({tag, ".busy_done"}, busy,        1'b0);
    chk({tag, ".digit"},     digit,       m_idx);
    chk({tag, ".led"},       led_onehot,  e_led);
    chk({tag, ".best"},      best_score,  $unsigned(m_best));
`ifdef ARGMAX_CONFIDENCE_EN
    chk({tag, ".margin"},    margin,      m_margin[31:0]);
    chk({tag, ".low_conf"},  low_conf,    m_low);
`endif
  endtask

  task automatic run(input string tag);
    start_pulse();
    wait_result(tag);
    @(negedge clk);
    chk({tag, ".strobe_1cyc"}, digit_valid, 1'b0);
  endtask

  initial begin
    int pulses;
    logic [3:0] got_digit;

    rst = 1'b1; start = 1'b0; scores = '0;
    repeat (3) @(negedge clk);
    chk("rst.busy",  busy,        1'b0);
    chk("rst.valid", digit_valid, 1'b0);
    chk("rst.digit", digit,       4'd0);
    chk("rst.led",   led_onehot,  10'd0);
    chk("rst.best",  best_score,  32'd0);
`ifdef ARGMAX_CONFIDENCE_EN
    chk("rst.margin", margin,   32'd0);
    chk("rst.low",    low_conf, 1'b0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Basic case: the maximum value 9 is at index 5.
    sv = '{3, -1, 7, 2, 0, 9, 4, 1, -8, 5};
    run("basic");
    chk("basic.digit5", digit,      4'd5);
    chk("basic.led5",   led_onehot, 10'b0000100000);
    chk("basic.best9",  best_score, 32'd9);

    // Ties resolve to the lowest index.
    sv = '{4, 4, 1, 4, 0, 0, 0, 0, 0, 0};
    run("tie0");
    chk("tie0.digit0", digit, 4'd0);
    sv = '{3, 0, 0, 0, 0, 0, 0, 4, 0, 0};
    run("tie7");
    chk("tie7.digit7", digit, 4'd7);

    // Negative and all-equal score sets.
    sv = '{-5, -5, -5, -5, -5, -5, -5, -5, -5, -5};
    run("all_m5");
    chk("all_m5.best", best_score, 32'hFFFF_FFFB);
    sv = '{-9, -3, -7, -2, -100, -6, -4, -11, -8, -1};
    run("neg9");
    chk("neg9.led", led_onehot, 10'b1000000000);

    // Confidence vectors. With the feature disabled, they still exercise argmax.
    sv = '{0, 900, 1000, 5, 0, 0, 0, 0, 0, 0};
    run("conf_low");
    sv = '{0, 100, 0, 0, 2000, 0, 0, 0, 0, 0};
    run("conf_high");
    // Extreme values: the margin subtraction must saturate.
    sv = '{int'(32'h8000_0000), int'(32'h8000_0000), int'(32'h7FFF_FFFF), int'(32'h8000_0000),
           int'(32'h8000_0000), int'(32'h8000_0000), int'(32'h8000_0000), int'(32'h8000_0000),
           int'(32'h8000_0000), int'(32'h8000_0000)};
    run("sat");

    // A start pulse arriving in the same cycle as digit_valid is accepted.
    sv = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    start_pulse();
    wait_result("b2b_a");
    sv = '{50, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    start_pulse();
    wait_result("b2b_b");
    @(negedge clk);

    // A second start during a scan is ignored; the result comes from the first snapshot.
    sv = '{3, -1, 7, 2, 0, 9, 4, 1, -8, 5};
    start_pulse();
    repeat (2) @(negedge clk);
    for (int k = 0; k < N; k++) scores[k*W +: W] = (k == 0) ? 32'd1000 : 32'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ref_model();
    pulses = 0;
    got_digit = 4'hF;
    for (int i = 0; i < 25; i++) begin
      if (digit_valid === 1'b1) begin pulses++; got_digit = digit; end
      @(negedge clk);
    end
    chk("overlap.pulses", pulses,    1);
    chk("overlap.digit",  got_digit, m_idx);

    // Reset during a scan aborts it and clears all outputs.
    sv = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    start_pulse();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort.busy",  busy,        1'b0);
    chk("abort.valid", digit_valid, 1'b0);
    chk("abort.digit", digit,       4'd0);
    chk("abort.led",   led_onehot,  10'd0);
    chk("abort.best",  best_score,  32'd0);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      if (digit_valid === 1'b1) pulses++;
      @(negedge clk);
    end
    chk("abort.no_valid", pulses, 0);
    sv = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    run("post_rst");

    // Random score sets: narrow ranges to force ties, plus full-range values.
    for (int it = 0; it < 24; it++) begin
      for (int k = 0; k < N; k++) begin
        case (it % 3)
          0:       sv[k] = int'($urandom_range(0, 6)) - 3;
          1:       sv[k] = int'($urandom);
          default: sv[k] = int'($urandom_range(0, 4000)) - 2000;
        endcase
      end
      run("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/argmax_classifier.md
Name: argmax_classifier

Overview:
- Final inference stage. Sits directly downstream of the ten layer-2 neurons.
- Takes a snapshot of the ten signed layer-2 scores when layer 2 completes.
- Scans the snapshot serially, one class per cycle, to find the maximum.
- Outputs the predicted digit as binary, as a one-hot LED vector for LEDR, and with a one-cycle result strobe.

Parameters:
- NUM_CLASSES, 10, number of scores scanned; must be ≥2.
- DATA_WIDTH, 32, width of each signed score.
- IDX_WIDTH, 4, width of the class index; must satisfy 2^IDX_WIDTH ≥ NUM_CLASSES.
- MARGIN_THRESH, 32'sd256, low-confidence threshold; used only when ARGMAX_CONFIDENCE_EN is defined.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse from the controller when layer-2 accumulation is complete.
- scores  in  NUM_CLASSES*DATA_WIDTH  packed signed scores; class k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- busy  out  1  high while a scan is in progress.
- digit_valid  out  1  one-cycle strobe: a new result is present on the outputs.
- digit  out  IDX_WIDTH  predicted class index.
- led_onehot  out  NUM_CLASSES  one-hot of digit; drives LEDR.
- best_score  out  DATA_WIDTH  signed score of the winning class.
- margin  out  DATA_WIDTH  winning score minus runner-up score; present only with ARGMAX_CONFIDENCE_EN.
- low_conf  out  1  margin < MARGIN_THRESH; present only with ARGMAX_CONFIDENCE_EN.

Behaviour:
- Reset (sync, rst=1 at an edge) drives all outputs to 0:
  - busy=0, digit_valid=0, digit=0, led_onehot=0, best_score=0, margin=0, low_conf=0.
  - FSM goes to IDLE.
  - rst during SCAN aborts the scan; no digit_valid is produced.
- FSM states: IDLE, SCAN.
- IDLE:
  - start=1 at an edge: register all scores into an internal snapshot.
  - Set working best_val=score[0], best_idx=0, idx=1, then go to SCAN and set busy=1.
  - The snapshot decouples the block from the upstream neuron outputs; later changes to scores do not affect the scan in progress.
- SCAN, one class per edge:
  - If snap[idx] > best_val (signed, strictly greater), then best_val<=snap[idx] and best_idx<=idx.
  - idx increments by 1.
- Final SCAN edge, idx==NUM_CLASSES-1:
  - Fold the comparison above into the result.
  - Register digit, best_score and led_onehot (bit digit set, all others 0).
  - digit_valid<=1 for one cycle, busy<=0, go to IDLE.
- Latency: digit_valid is high in the cycle following the (NUM_CLASSES-1)th edge after the edge that samples start (9 edges for the default). busy is high for exactly NUM_CLASSES-1 cycles.
- Ties: the lowest index wins, because the comparison is strict.
- start while busy=1 is ignored; the scan in progress is unaffected.
- start in the cycle digit_valid=1 is accepted (FSM is already IDLE).
- digit, led_onehot and best_score hold their values until the next result or reset.
- All-equal or all-negative scores are handled by the same signed rules; e.g. all -5 → digit 0.
- No multiply; one signed DATA_WIDTH comparator.
- The index mux reads the snapshot at idx.

Optional Feature:
- Macro: ARGMAX_CONFIDENCE_EN.
- Defined:
  - Track second_val (runner-up score), initialised to the most negative DATA_WIDTH value at scan start.
  - On a new best: second_val<=best_val.
  - Else, if snap[idx] > second_val: second_val<=snap[idx].
  - At result: margin<=best_val-second_val, with the subtraction computed at DATA_WIDTH+1 bits and saturated to the DATA_WIDTH signed maximum.
  - low_conf<=(margin<MARGIN_THRESH).
  - Both outputs update together with digit_valid; both reset to 0.
- Undefined: the margin and low_conf ports, the second_val register and the subtractor do not exist; behaviour is otherwise identical.

Test Plan:
- Scores {3,-1,7,2,0,9,4,1,-8,5}, start pulse → busy high for 9 cycles; then digit_valid=1 for one cycle, digit=5, led_onehot=10'b0000100000, best_score=9.
- Scores {4,4,1,4,…,0} (indices 0, 1 and 3 equal at 4) → digit=0. Second run with index 7 = 4 and index 0 = 3, all others below 3 → digit=7.
- All scores -5 → digit=0, best_score=-5. All scores negative, with index 9 = -1 as the maximum → digit=9, led_onehot=10'b1000000000.
- Start a scan, then change scores and pulse start again 3 cycles in → result reflects the first snapshot only; exactly one digit_valid pulse.
- Assert rst 4 cycles into a scan → next cycle all outputs 0, busy=0; no digit_valid. A fresh start afterwards completes normally after 9 cycles.
- With ARGMAX_CONFIDENCE_EN: scores best=1000, runner-up=900 → margin=100, low_conf=1. Scores best=2000, runner-up=100 → margin=1900, low_conf=0.
